// File: rtl/board_update_scheduler_pkg.sv
// Shared types and constants for the board tile-map update scheduler.
package board_pkg;

    localparam int ROWS       = 8;
    localparam int COLS       = 10;
    localparam int CELLS      = ROWS * COLS;
    localparam int FIFO_DEPTH = 4;
    localparam int ADDR_W     = 7;
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;

    // Tile codes understood by the renderer.
    localparam logic [3:0] TILE_RED     = 4'h1;
    localparam logic [3:0] TILE_GREEN   = 4'h2;
    localparam logic [3:0] TILE_BLUE    = 4'h3;
    localparam logic [3:0] TILE_YELLOW  = 4'h4;
    localparam logic [3:0] TILE_CYAN    = 4'h5;
    localparam logic [3:0] TILE_MAGENTA = 4'h6;
    localparam logic [3:0] TILE_ORANGE  = 4'h7;
    localparam logic [3:0] TILE_BLACK   = 4'h8;
    localparam logic [3:0] TILE_WHITE   = 4'h9;
    localparam logic [3:0] TILE_GRAY    = 4'hA;

    localparam logic [3:0] CLEAR_CODE   = TILE_BLACK;

    typedef struct packed {
        logic [2:0] row;
        logic [3:0] col;
        logic [3:0] code;
    } tile_req_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_CLEAR
    } sched_state_t;

    // Linear tile-map address; row*COLS is a constant multiply.
    function automatic logic [ADDR_W-1:0] tile_addr(input logic [2:0] row, input logic [3:0] col);
        return ADDR_W'(row) * ADDR_W'(COLS) + ADDR_W'(col);
    endfunction

endpackage

// File: rtl/board_update_scheduler_if.sv
// Requester, clear, status and tile-map write signals of the scheduler.
interface board_update_scheduler_if;
    import board_pkg::*;

    logic              vblank;
    logic              req0_valid;
    logic              req0_ready;
    logic [2:0]        req0_row;
    logic [3:0]        req0_col;
    logic [3:0]        req0_code;
    logic              req1_valid;
    logic              req1_ready;
    logic [2:0]        req1_row;
    logic [3:0]        req1_col;
    logic [3:0]        req1_code;
    logic              clr_req;
    logic              clr_busy;
    logic              map_we;
    logic [ADDR_W-1:0] map_addr;
    logic [3:0]        map_wdata;
    logic [CNT_W-1:0]  pending;
    logic              commit_done;
    logic              err_drop;

    // Game logic / timing side.
    modport master (
        output vblank, req0_valid, req0_row, req0_col, req0_code,
               req1_valid, req1_row, req1_col, req1_code, clr_req,
        input  req0_ready, req1_ready, clr_busy, map_we, map_addr, map_wdata,
               pending, commit_done, err_drop
    );

    // Scheduler side.
    modport slave (
        input  vblank, req0_valid, req0_row, req0_col, req0_code,
               req1_valid, req1_row, req1_col, req1_code, clr_req,
        output req0_ready, req1_ready, clr_busy, map_we, map_addr, map_wdata,
               pending, commit_done, err_drop
    );

endinterface

// File: rtl/board_update_scheduler_fifo.sv
// Small synchronous FIFO of tile write requests; head is read combinationally.
module tile_req_fifo
    import board_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  tile_req_t                din,
    input  logic                     pop,
    output tile_req_t                dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);

    tile_req_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    assign dout  = mem[rd_ptr];
    assign full  = (count == (PTR_W+1)'(DEPTH));
    assign empty = (count == '0);

    // Storage needs no reset; occupancy decides what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    // Pointers and occupancy; the caller never pushes when full or pops when empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/board_update_scheduler.sv
// Arbitrates two tile-write requesters into a FIFO and commits queued writes
// (or a full-board clear sweep) to the tile map only during vblank.
module board_update_scheduler
    import board_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    board_update_scheduler_if.slave bus
);
    tile_req_t         req0, req1, acc_req, head;
    logic              full, empty;
    logic              both, rr, acc0, acc1, accepted, bad_col, push, pop;
    logic              vb_q, rise;
    logic              clr_busy, clr_wr, clr_last, done_set;
    logic [ADDR_W-1:0] clr_cnt;
    logic              map_we;
    logic [ADDR_W-1:0] map_addr;
    logic [3:0]        map_wdata;
    logic              commit_done, err_drop;
    sched_state_t      state, state_nx;

    assign req0 = '{row: bus.req0_row, col: bus.req0_col, code: bus.req0_code};
    assign req1 = '{row: bus.req1_row, col: bus.req1_col, code: bus.req1_code};

    // Round-robin only matters on contention; the loser sees ready low.
    assign both           = bus.req0_valid & bus.req1_valid;
    assign bus.req0_ready = !full && !(both &&  rr);
    assign bus.req1_ready = !full && !(both && !rr);
    assign acc0           = bus.req0_valid & bus.req0_ready;
    assign acc1           = bus.req1_valid & bus.req1_ready;
    assign accepted       = acc0 | acc1;
    assign acc_req        = acc1 ? req1 : req0;
    assign bad_col        = 32'(acc_req.col) >= COLS;
    assign push           = accepted & !bad_col;

    assign rise     = bus.vblank & !vb_q;
    assign clr_last = (clr_cnt == ADDR_W'(CELLS - 1));

    tile_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (acc_req),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (bus.pending)
    );

    // Arbiter pointer, vblank edge detect and bad-column flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr       <= 1'b0;
            vb_q     <= 1'b0;
            err_drop <= 1'b0;
        end else begin
            if (both && !full) rr <= !rr;
            vb_q     <= bus.vblank;
            err_drop <= accepted & bad_col;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    // Next state: a commit window opens on the vblank rising edge; a pending clear wins.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (rise) begin
                    if (clr_busy)    state_nx = ST_CLEAR;
                    else if (!empty) state_nx = ST_DRAIN;
                end
            end
            ST_DRAIN: if (empty || !bus.vblank) state_nx = ST_IDLE;
            ST_CLEAR: if (bus.vblank && clr_last) state_nx = empty ? ST_IDLE : ST_DRAIN;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // Per-cycle strobes: the first write of a window happens on the rising-edge cycle itself.
    always_comb begin
        pop      = 1'b0;
        clr_wr   = 1'b0;
        done_set = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rise) begin
                    if (clr_busy)    clr_wr = 1'b1;
                    else if (!empty) pop    = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (bus.vblank && !empty) pop      = 1'b1;
                else                      done_set = 1'b1;
            end
            ST_CLEAR: begin
                if (bus.vblank) begin
                    clr_wr   = 1'b1;
                    done_set = clr_last && empty;
                end
            end
            default: ;
        endcase
    end

    // Clear request latch and sweep counter; the counter holds while vblank is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_busy <= 1'b0;
            clr_cnt  <= '0;
        end else begin
            if (clr_wr) clr_cnt <= clr_last ? '0 : clr_cnt + 1'b1;
            if (clr_wr && clr_last) clr_busy <= 1'b0;
            else if (bus.clr_req)   clr_busy <= 1'b1;
        end
    end

    // Registered tile-map write port and commit-done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            map_we      <= 1'b0;
            map_addr    <= '0;
            map_wdata   <= '0;
            commit_done <= 1'b0;
        end else begin
            commit_done <= done_set;
            if (pop) begin
                map_we    <= 1'b1;
                map_addr  <= tile_addr(head.row, head.col);
                map_wdata <= head.code;
            end else if (clr_wr) begin
                map_we    <= 1'b1;
                map_addr  <= clr_cnt;
                map_wdata <= CLEAR_CODE;
            end else begin
                map_we    <= 1'b0;
            end
        end
    end

    assign bus.map_we      = map_we;
    assign bus.map_addr    = map_addr;
    assign bus.map_wdata   = map_wdata;
    assign bus.commit_done = commit_done;
    assign bus.err_drop    = err_drop;
    assign bus.clr_busy    = clr_busy;

endmodule

// File: tb/tb_board_update_scheduler.sv
// Directed bench for board_update_scheduler with a queue-based reference model.
module tb_board_update_scheduler;
    import board_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    board_update_scheduler_if bus();

    board_update_scheduler dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the queue holds the accepted, legal writes in order.
    tile_req_t  mq[$];
    bit         m_rr, m_vbp, m_busy;
    int         m_mode;      // 0 waiting for vblank, 1 committing queued writes, 2 sweeping clear
    int         m_sweep;
    bit         e_we, e_done, e_err;
    logic [6:0] e_addr;
    logic [3:0] e_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_rr = 0; m_vbp = 0; m_busy = 0; m_mode = 0; m_sweep = 0;
        e_we = 0; e_done = 0; e_err = 0; e_addr = '0; e_data = '0;
    endtask

    // One clock of the specified behaviour, evaluated on the inputs present at the edge.
    task automatic model_step();
        bit        rise, swept_all;
        int        n, g;
        tile_req_t h, r;
        rise      = bus.vblank && !m_vbp;
        n         = mq.size();
        swept_all = 0;
        e_we = 0; e_done = 0; e_err = 0;
        if (m_mode == 0 && rise) m_mode = m_busy ? 2 : ((n != 0) ? 1 : 0);
        if (m_mode == 1) begin
            if (bus.vblank && n != 0) begin
                h      = mq.pop_front();
                e_we   = 1;
                e_addr = 7'(int'(h.row) * 10 + int'(h.col));
                e_data = h.code;
            end else begin
                m_mode = 0;
                e_done = 1;
            end
        end else if (m_mode == 2 && bus.vblank) begin
            e_we   = 1;
            e_addr = 7'(m_sweep);
            e_data = 4'h8;
            if (m_sweep == 79) begin
                m_sweep   = 0;
                swept_all = 1;
                m_busy    = 0;
                if (n != 0) m_mode = 1;
                else begin
                    m_mode = 0;
                    e_done = 1;
                end
            end else begin
                m_sweep++;
            end
        end
        if (bus.clr_req && !swept_all) m_busy = 1;
        g = -1;
        if (n < 4) begin
            if (bus.req0_valid && bus.req1_valid) begin
                g    = m_rr ? 1 : 0;
                m_rr = !m_rr;
            end else if (bus.req0_valid) g = 0;
            else if (bus.req1_valid)     g = 1;
        end
        if (g >= 0) begin
            if (g == 1) r = '{row: bus.req1_row, col: bus.req1_col, code: bus.req1_code};
            else        r = '{row: bus.req0_row, col: bus.req0_col, code: bus.req0_code};
            if (int'(r.col) >= 10) e_err = 1;
            else                   mq.push_back(r);
        end
        m_vbp = bus.vblank;
    endtask

    always @(posedge clk) begin
        if (rst) model_reset();
        else     model_step();
    end

    // Compare every output against the model on each falling edge out of reset.
    task automatic compare_all();
        bit both, full;
        both = bus.req0_valid && bus.req1_valid;
        full = (mq.size() == 4);
        chk("ready0",      bus.req0_ready,  32'(!full && !(both &&  m_rr)));
        chk("ready1",      bus.req1_ready,  32'(!full && !(both && !m_rr)));
        chk("pending",     bus.pending,     32'(mq.size()));
        chk("map_we",      bus.map_we,      32'(e_we));
        if (e_we) begin
            chk("map_addr",  bus.map_addr,  32'(e_addr));
            chk("map_wdata", bus.map_wdata, 32'(e_data));
        end
        chk("commit_done", bus.commit_done, 32'(e_done));
        chk("err_drop",    bus.err_drop,    32'(e_err));
        chk("clr_busy",    bus.clr_busy,    32'(m_busy));
    endtask

    always @(negedge clk) begin
        if (!rst) compare_all();
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic set_req0(input bit v, input logic [2:0] row, input logic [3:0] col, input logic [3:0] code);
        bus.req0_valid = v; bus.req0_row = row; bus.req0_col = col; bus.req0_code = code;
    endtask

    task automatic set_req1(input bit v, input logic [2:0] row, input logic [3:0] col, input logic [3:0] code);
        bus.req1_valid = v; bus.req1_row = row; bus.req1_col = col; bus.req1_code = code;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.vblank  = 1'b0;
        bus.clr_req = 1'b0;
        set_req0(0, 3'd0, 4'd0, 4'd0);
        set_req1(0, 3'd0, 4'd0, 4'd0);

        // Reset state
        cyc(2); at_neg();
        chk("rst_map_we",   bus.map_we,      0);
        chk("rst_pending",  bus.pending,     0);
        chk("rst_clr_busy", bus.clr_busy,    0);
        chk("rst_done",     bus.commit_done, 0);
        chk("rst_ready0",   bus.req0_ready,  1);
        rst = 1'b0;
        cyc(1);

        // Single write, committed on the next vblank
        set_req0(1, 3'd3, 4'd2, 4'h1); cyc(1); set_req0(0, 3'd0, 4'd0, 4'd0);
        at_neg();
        chk("t1_pending", bus.pending, 1);
        chk("t1_no_we",   bus.map_we,  0);
        bus.vblank = 1'b1; cyc(1); at_neg();
        chk("t1_we",   bus.map_we,    1);
        chk("t1_addr", bus.map_addr,  32);
        chk("t1_data", bus.map_wdata, 1);
        cyc(1); at_neg();
        chk("t1_done", bus.commit_done, 1);
        bus.vblank = 1'b0; cyc(2);

        // Bad column is accepted but dropped
        set_req1(1, 3'd2, 4'd12, 4'h4); at_neg();
        chk("t3_ready1", bus.req1_ready, 1);
        cyc(1); set_req1(0, 3'd0, 4'd0, 4'd0); at_neg();
        chk("t3_err",     bus.err_drop, 1);
        chk("t3_pending", bus.pending,  0);
        cyc(1); at_neg();
        chk("t3_err_off", bus.err_drop, 0);
        cyc(1);

        // Contention: 0,1,0,1 then both stalled on a full FIFO
        for (int i = 0; i < 4; i++) begin
            set_req0(1, 3'd1, 4'(i), 4'h2);
            set_req1(1, 3'd2, 4'(i), 4'h3);
            cyc(1);
        end
        at_neg();
        chk("t2_pending", bus.pending,    4);
        chk("t2_ready0",  bus.req0_ready, 0);
        chk("t2_ready1",  bus.req1_ready, 0);
        cyc(1);
        set_req0(0, 3'd0, 4'd0, 4'd0);
        set_req1(0, 3'd0, 4'd0, 4'd0);
        cyc(2);

        // Short vblank: two writes, then the rest on the next vblank
        bus.vblank = 1'b1; cyc(1); at_neg();
        chk("t4_addr_a", bus.map_addr,  10);
        chk("t4_data_a", bus.map_wdata, 2);
        cyc(1); at_neg();
        chk("t4_addr_b", bus.map_addr,  21);
        chk("t4_data_b", bus.map_wdata, 3);
        bus.vblank = 1'b0; cyc(1); at_neg();
        chk("t4_done",    bus.commit_done, 1);
        chk("t4_pending", bus.pending,     2);
        cyc(3);
        bus.vblank = 1'b1; cyc(1); at_neg();
        chk("t4_addr_c", bus.map_addr, 12);
        cyc(1); at_neg();
        chk("t4_addr_d", bus.map_addr,  23);
        chk("t4_data_d", bus.map_wdata, 3);
        cyc(1); at_neg();
        chk("t4_done2",    bus.commit_done, 1);
        chk("t4_pending2", bus.pending,     0);
        bus.vblank = 1'b0; cyc(2);

        // Clear split across two vblanks, with a write queued behind it
        bus.clr_req = 1'b1; cyc(1); bus.clr_req = 1'b0; at_neg();
        chk("t5_busy", bus.clr_busy, 1);
        bus.vblank = 1'b1; cyc(1); at_neg();
        chk("t5_addr0", bus.map_addr,  0);
        chk("t5_data0", bus.map_wdata, 8);
        cyc(49); at_neg();
        chk("t5_addr49", bus.map_addr, 49);
        bus.vblank = 1'b0; cyc(1); at_neg();
        chk("t5_hold_we",   bus.map_we,   0);
        chk("t5_hold_busy", bus.clr_busy, 1);
        set_req0(1, 3'd7, 4'd9, 4'h5); cyc(1); set_req0(0, 3'd0, 4'd0, 4'd0);
        cyc(2);
        bus.vblank = 1'b1; cyc(30); at_neg();
        chk("t5_addr79", bus.map_addr,  79);
        chk("t5_data79", bus.map_wdata, 8);
        chk("t5_idle",   bus.clr_busy,  0);
        cyc(1); at_neg();
        chk("t5_q_addr", bus.map_addr,  79);
        chk("t5_q_data", bus.map_wdata, 5);
        cyc(1); at_neg();
        chk("t5_done", bus.commit_done, 1);
        bus.vblank = 1'b0; cyc(2);

        // Reset in the middle of a commit burst
        for (int i = 0; i < 3; i++) begin
            set_req0(1, 3'd0, 4'(i), 4'h6);
            cyc(1);
        end
        set_req0(0, 3'd0, 4'd0, 4'd0);
        bus.vblank = 1'b1; cyc(1);
        chk("t6_we_before", bus.map_we, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_we_rst",      bus.map_we,  0);
        chk("t6_pending_rst", bus.pending, 0);
        bus.vblank = 1'b0;
        cyc(1);
        rst = 1'b0;
        at_neg();
        chk("t6_ready0", bus.req0_ready, 1);
        chk("t6_ready1", bus.req1_ready, 1);
        cyc(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
